// File: rtl/cache_control.sv
// cache_control: 2-way set-associative L1 controller (hit decode, writeback, fill); CACHE_PERF_COUNTERS_EN adds hit/miss/writeback counters
module cache_control #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX = 3,
   parameter int S_TAG = 24
) (
   input logic clk,
   input logic rst,
   input logic mem_read,
   input logic mem_write,
   input logic [31:0] mem_address,
   output logic mem_resp,
   input logic hit1,
   input logic hit2,
   input logic dirty1,
   input logic dirty2,
   input logic lru,
   input logic [S_TAG-1:0] tag1,
   input logic [S_TAG-1:0] tag2,
   input logic pmem_resp,
   output logic pmem_read,
   output logic pmem_write,
   output logic [31:0] pmem_address,
   output logic way_sel,
   output logic data_src,
   output logic ld_data1,
   output logic ld_data2,
   output logic ld_tag1,
   output logic ld_tag2,
   output logic ld_dirty1,
   output logic ld_dirty2,
   output logic dirty_in,
   output logic ld_lru,
   output logic lru_out
`ifdef CACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [31:0] wb_count
`endif
);

   localparam logic [31:0] LINE_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

   typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

   state_t state, next;
   logic req, hit, hw, v, vd;
   logic [S_TAG-1:0] vtag;

   assign req = mem_read | mem_write;
   assign hit = hit1 | hit2;
   assign hw = ~hit1 & hit2;
   assign v = lru;
   assign vd = v ? dirty2 : dirty1;
   assign vtag = v ? tag2 : tag1;

   // state register; reset forces CHECK so memory requests drop immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CHECK;
      else state <= next;
   end

   // next state and all array/memory controls; everything held low during reset
   always_comb begin
      next = state;
      mem_resp = 1'b0;
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      pmem_address = '0;
      way_sel = 1'b0;
      data_src = 1'b0;
      ld_data1 = 1'b0;
      ld_data2 = 1'b0;
      ld_tag1 = 1'b0;
      ld_tag2 = 1'b0;
      ld_dirty1 = 1'b0;
      ld_dirty2 = 1'b0;
      dirty_in = 1'b0;
      ld_lru = 1'b0;
      lru_out = 1'b0;
      if (!rst) begin
         case (state)
            CHECK: begin
               if (req && hit) begin
                  mem_resp = 1'b1;
                  way_sel = hw;
                  ld_lru = 1'b1;
                  lru_out = ~hw;
                  ld_data1 = mem_write & ~hw;
                  ld_data2 = mem_write & hw;
                  ld_dirty1 = mem_write & ~hw;
                  ld_dirty2 = mem_write & hw;
                  dirty_in = mem_write;
               end else if (req) begin
                  next = vd ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               pmem_write = 1'b1;
               way_sel = v;
               pmem_address = {vtag, mem_address[S_OFFSET+S_INDEX-1:S_OFFSET], {S_OFFSET{1'b0}}};
               if (pmem_resp) next = req ? ALLOCATE : CHECK;
            end
            ALLOCATE: begin
               pmem_read = 1'b1;
               way_sel = v;
               pmem_address = mem_address & LINE_MASK;
               if (pmem_resp) begin
                  data_src = 1'b1;
                  ld_data1 = ~v;
                  ld_data2 = v;
                  ld_tag1 = ~v;
                  ld_tag2 = v;
                  ld_dirty1 = ~v;
                  ld_dirty2 = v;
                  next = CHECK;
               end
            end
            default: next = CHECK;
         endcase
      end
   end

`ifdef CACHE_PERF_COUNTERS_EN
   logic check_req;
   assign check_req = (state == CHECK) & req;

   // saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count <= '0;
         miss_count <= '0;
         wb_count <= '0;
      end else begin
         if (check_req && hit && hit_count != '1) hit_count <= hit_count + 32'd1;
         if (check_req && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
         if (check_req && !hit && vd && wb_count != '1) wb_count <= wb_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed self-checking bench for cache_control
module tb_cache_control;

   logic clk = 1'b0;
   logic rst, mem_read, mem_write, mem_resp;
   logic [31:0] mem_address, pmem_address;
   logic hit1, hit2, dirty1, dirty2, lru, pmem_resp, pmem_read, pmem_write;
   logic [23:0] tag1, tag2;
   logic way_sel, data_src, ld_data1, ld_data2, ld_tag1, ld_tag2;
   logic ld_dirty1, ld_dirty2, dirty_in, ld_lru, lru_out;
`ifdef CACHE_PERF_COUNTERS_EN
   logic [31:0] hit_count, miss_count, wb_count;
`endif
   logic [13:0] ctl, exp;
   int checks = 0;
   int fails = 0;

   // {mem_resp, pmem_read, pmem_write, way_sel, data_src, ld_data1, ld_data2,
   //  ld_tag1, ld_tag2, ld_dirty1, ld_dirty2, dirty_in, ld_lru, lru_out}
   assign ctl = {mem_resp, pmem_read, pmem_write, way_sel, data_src, ld_data1, ld_data2,
                 ld_tag1, ld_tag2, ld_dirty1, ld_dirty2, dirty_in, ld_lru, lru_out};

   cache_control dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_resp(mem_resp), .hit1(hit1), .hit2(hit2),
      .dirty1(dirty1), .dirty2(dirty2), .lru(lru), .tag1(tag1), .tag2(tag2),
      .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .way_sel(way_sel), .data_src(data_src),
      .ld_data1(ld_data1), .ld_data2(ld_data2), .ld_tag1(ld_tag1), .ld_tag2(ld_tag2),
      .ld_dirty1(ld_dirty1), .ld_dirty2(ld_dirty2), .dirty_in(dirty_in),
      .ld_lru(ld_lru), .lru_out(lru_out)
`ifdef CACHE_PERF_COUNTERS_EN
      , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic idle();
      mem_read = 0; mem_write = 0; mem_address = 32'h0; hit1 = 0; hit2 = 0;
      dirty1 = 0; dirty2 = 0; lru = 0; tag1 = 24'h111111; tag2 = 24'h222222; pmem_resp = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle(); mem_read = 1; hit1 = 1;
      #2;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL reset_ctl got %b exp %b", ctl, 14'b0); end
      checks++; if (pmem_address !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp %h", pmem_address, 32'h0); end
      @(negedge clk); rst = 0; idle();
      #1;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL idle_ctl got %b exp %b", ctl, 14'b0); end
   endtask

   task automatic test_read_hit();
      @(negedge clk); mem_read = 1; hit2 = 1; lru = 1;
      #1; exp = 14'b10010000000010;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL rd_hit_ctl got %b exp %b", ctl, exp); end
      @(negedge clk); idle();
      #1;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL rd_hit_after got %b exp %b", ctl, 14'b0); end
   endtask

   task automatic test_write_hit();
      @(negedge clk); mem_write = 1; hit1 = 1;
      #1; exp = 14'b10000100010111;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL wr_hit_ctl got %b exp %b", ctl, exp); end
      @(negedge clk); mem_read = 1; mem_write = 1; hit1 = 1; hit2 = 1;
      #1;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL both_hit_ctl got %b exp %b", ctl, exp); end
      @(negedge clk); idle();
   endtask

   task automatic test_clean_miss();
      @(negedge clk); mem_read = 1; mem_address = 32'h0000_1234;
      #1;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL cm_check got %b exp %b", ctl, 14'b0); end
      @(negedge clk); #1; exp = 14'b01000000000000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL cm_alloc got %b exp %b", ctl, exp); end
      checks++; if (pmem_address !== 32'h0000_1220) begin fails++; $display("FAIL cm_addr got %h exp %h", pmem_address, 32'h0000_1220); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL cm_hold got %b exp %b", ctl, exp); end
      pmem_resp = 1;
      #1; exp = 14'b01001101010000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL cm_fill got %b exp %b", ctl, exp); end
      @(negedge clk); pmem_resp = 0; hit1 = 1;
      #1; exp = 14'b10000000000011;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL cm_rehit got %b exp %b", ctl, exp); end
      @(negedge clk); idle();
   endtask

   task automatic test_dirty_miss();
      @(negedge clk); mem_read = 1; mem_address = 32'h0000_1234; lru = 1; dirty2 = 1; tag2 = 24'hABCDEF;
      #1;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL dm_check got %b exp %b", ctl, 14'b0); end
      @(negedge clk); #1; exp = 14'b00110000000000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL dm_wb got %b exp %b", ctl, exp); end
      checks++; if (pmem_address !== 32'hABCD_EF20) begin fails++; $display("FAIL dm_wb_addr got %h exp %h", pmem_address, 32'hABCD_EF20); end
      @(negedge clk); pmem_resp = 1;
      #1;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL dm_wb_resp got %b exp %b", ctl, exp); end
      @(negedge clk); pmem_resp = 0;
      #1; exp = 14'b01010000000000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL dm_alloc got %b exp %b", ctl, exp); end
      checks++; if (pmem_address !== 32'h0000_1220) begin fails++; $display("FAIL dm_fill_addr got %h exp %h", pmem_address, 32'h0000_1220); end
      @(negedge clk); pmem_resp = 1;
      #1; exp = 14'b01011010101000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL dm_fill got %b exp %b", ctl, exp); end
      @(negedge clk); pmem_resp = 0; hit2 = 1;
      #1; exp = 14'b10010000000010;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL dm_rehit got %b exp %b", ctl, exp); end
      @(negedge clk); idle();
   endtask

   task automatic test_req_drop();
      @(negedge clk); mem_write = 1; mem_address = 32'h0000_0044;
      @(negedge clk); mem_write = 0;
      #1; exp = 14'b01000000000000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL drop_alloc got %b exp %b", ctl, exp); end
      checks++; if (pmem_address !== 32'h0000_0040) begin fails++; $display("FAIL drop_addr got %h exp %h", pmem_address, 32'h0000_0040); end
      pmem_resp = 1;
      #1; exp = 14'b01001101010000;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL drop_fill got %b exp %b", ctl, exp); end
      @(negedge clk); pmem_resp = 0;
      #1;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL drop_check got %b exp %b", ctl, 14'b0); end
      @(negedge clk); idle();
   endtask

   task automatic test_reset_mid_fill();
      @(negedge clk); mem_read = 1; mem_address = 32'h0000_1234;
      @(negedge clk); #1;
      checks++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL rmf_pre got %b exp %b", pmem_read, 1'b1); end
      pmem_resp = 1; rst = 1;
      #1;
      checks++; if (ctl !== 14'b0) begin fails++; $display("FAIL rmf_ctl got %b exp %b", ctl, 14'b0); end
      checks++; if (pmem_address !== 32'h0) begin fails++; $display("FAIL rmf_addr got %h exp %h", pmem_address, 32'h0); end
      @(negedge clk); rst = 0; pmem_resp = 0; hit1 = 1;
      #1; exp = 14'b10000000000011;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL rmf_check got %b exp %b", ctl, exp); end
      @(negedge clk); idle();
   endtask

`ifdef CACHE_PERF_COUNTERS_EN
   task automatic test_perf();
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      repeat (2) begin
         @(negedge clk); mem_read = 1; hit1 = 1;
      end
      @(negedge clk); idle(); mem_read = 1; mem_address = 32'h0000_1234; lru = 1; dirty2 = 1;
      @(negedge clk); pmem_resp = 1;
      @(negedge clk); pmem_resp = 1;
      @(negedge clk); pmem_resp = 0; hit2 = 1;
      @(negedge clk); idle();
      #1;
      checks++; if (hit_count !== 32'd3) begin fails++; $display("FAIL perf_hit got %0d exp 3", hit_count); end
      checks++; if (miss_count !== 32'd1) begin fails++; $display("FAIL perf_miss got %0d exp 1", miss_count); end
      checks++; if (wb_count !== 32'd1) begin fails++; $display("FAIL perf_wb got %0d exp 1", wb_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_req_drop();
      test_reset_mid_fill();
`ifdef CACHE_PERF_COUNTERS_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Sequential controller for the 2-way set-associative L1 data cache.
- Sits directly upstream of the write-hit merge block and drives it: it decodes hit/miss per way and selects the way whose line gets byte-merged.
- On a miss it sequences the dirty-victim writeback and the line fill over the physical memory port.
- Drives load enables for the data, tag, valid, dirty and LRU arrays. Datapath muxing stays in the cache datapath.

Parameters:
- S_OFFSET, 5, byte-offset bits (32-byte line).
- S_INDEX, 3, set-index bits.
- S_TAG, 24, tag bits; must equal 32 - S_OFFSET - S_INDEX.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_address  in  32  CPU byte address.
- mem_resp  out  1  request complete, one-cycle pulse.
- hit1, hit2  in  1  per-way tag match AND valid, from datapath.
- dirty1, dirty2  in  1  dirty bits of the indexed set.
- lru  in  1  LRU bit of the indexed set; 0 = way1 is victim.
- tag1, tag2  in  S_TAG  stored tags of the indexed set.
- pmem_resp  in  1  physical memory transfer done.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line-aligned physical address.
- way_sel  out  1  way for data write/readout; 0 = way1, 1 = way2.
- data_src  out  1  0 = merged write-hit data, 1 = pmem line.
- ld_data1, ld_data2  out  1  data array write enables.
- ld_tag1, ld_tag2  out  1  tag write enables; valid is set together with tag.
- ld_dirty1, ld_dirty2  out  1  dirty write enables.
- dirty_in  out  1  value written to dirty.
- ld_lru  out  1  LRU write enable.
- lru_out  out  1  LRU value written.

Behaviour:
- States: CHECK, WRITEBACK, ALLOCATE.
- Reset: state = CHECK; all outputs 0; pmem_address = 0.
- All outputs are combinational from state and inputs (Moore/Mealy mix). Only state, and the counters when enabled, are registers.
- req = mem_read | mem_write. Both asserted together is treated as a write.
- CHECK, no req:
  - Stay in CHECK; all enables 0.
- CHECK, req and (hit1 | hit2):
  - mem_resp = 1 in the same cycle (0-wait hit); way_sel = hit2.
  - ld_lru = 1, lru_out = ~hit2, i.e. the non-hit way becomes victim.
  - If write: ld_dataX = 1 for the hit way, data_src = 0, ld_dirtyX = 1, dirty_in = 1.
  - Stay in CHECK.
  - If hit1 and hit2 are both set (illegal), way1 wins.
- CHECK, req and no hit:
  - victim v = lru.
  - If dirty of way v is set, go to WRITEBACK; otherwise go to ALLOCATE.
  - mem_resp = 0 this cycle.
- WRITEBACK:
  - pmem_write = 1; way_sel = v.
  - pmem_address = {tag of way v, mem_address[S_OFFSET+S_INDEX-1:S_OFFSET], S_OFFSET'b0}.
  - On pmem_resp go to ALLOCATE.
- ALLOCATE:
  - pmem_read = 1; pmem_address = {mem_address[31:S_OFFSET], S_OFFSET'b0}.
  - On pmem_resp: ld_dataV = 1, data_src = 1, ld_tagV = 1, ld_dirtyV = 1, dirty_in = 0; go to CHECK.
  - The next CHECK cycle hits and completes the request, including the write merge.
- Miss latency: 1 + writeback wait (if dirty) + fill wait + 1 hit cycle.
- pmem_read and pmem_write are never asserted together. Each holds steadily until pmem_resp.
- The victim is recomputed each cycle from lru. LRU does not change during a miss, so v is stable.
- req dropping mid-miss (protocol violation): the current transfer completes, then the FSM returns to CHECK with mem_resp = 0.
- rst mid-transfer: pmem_read/pmem_write drop immediately (asynchronously); state goes to CHECK. No partial array writes occur.

Optional Feature:
- Macro CACHE_PERF_COUNTERS_EN.
- With it defined: adds outputs hit_count, miss_count, wb_count (32 bits each).
  - hit_count increments on each CHECK cycle with req and a hit, including the post-fill re-check.
  - miss_count increments on each CHECK-to-miss transition.
  - wb_count increments on entry to WRITEBACK.
  - All saturate at 32'hFFFFFFFF and are cleared by rst.
- Without it: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Read hit, way2: mem_read = 1, hit2 = 1, lru = 1 -> same cycle mem_resp = 1, way_sel = 1, ld_lru = 1, lru_out = 0, no data/dirty load.
- Write hit, way1: mem_write = 1, hit1 = 1 -> ld_data1 = 1, data_src = 0, ld_dirty1 = 1, dirty_in = 1, lru_out = 1, mem_resp = 1.
- Clean miss: mem_read, addr 0x0000_1234, lru = 0, dirty1 = 0 -> ALLOCATE, pmem_read = 1, pmem_address = 0x0000_1220. After pmem_resp at cycle 5: ld_data1 = ld_tag1 = 1, dirty_in = 0. Next cycle with hit1 = 1 -> mem_resp = 1.
- Dirty miss: lru = 1, dirty2 = 1, tag2 = 24'hABCDEF, addr 0x0000_1234 -> pmem_write = 1, pmem_address = 0xABCD_EF20. Then pmem_read at 0x0000_1220. No overlap of pmem_read and pmem_write.
- Reset mid-fill: assert rst while pmem_read = 1 -> pmem_read = 0 in the same cycle, state CHECK, no ld_* asserted.
- With CACHE_PERF_COUNTERS_EN: 2 read hits + 1 dirty miss -> hit_count = 3, miss_count = 1, wb_count = 1.
